// File: rtl/lru_pkg.sv
// Shared types and constants for the LRU buffer access arbiter.
// The package holds the state encoding, default widths and the pointer wrap helper.
package lru_pkg;

    localparam int unsigned DATA_W_DEF   = 12;
    localparam int unsigned LRU_MIN_BUSY = 11;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned MAX_REQ      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Next requester index after idx, wrapping modulo n.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      n);
        logic [31:0] nxt;
        nxt = 32'(idx) + 32'd1;
        return (nxt >= n) ? '0 : IDX_W'(nxt);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request bit at or above
// rr_ptr, wrapping modulo N_REQ.
module rr_pick
    import lru_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = IDX_W'((32'(rr_ptr) + k) % N_REQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                sel_idx  = pos;
                sel[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lru_access_arbiter.sv
// Serialises up to four requesters onto one LRU buffer write port, holding
// each entry stable for a fixed service window and reporting completion.
module lru_access_arbiter
    import lru_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned BUSY_CYCLES = 12,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    lru_valid,
    output logic [DATA_W-1:0]       lru_data,
    output logic                    busy,
    output logic [IDX_W-1:0]        last_src,
    output logic [CNT_W-1:0]        txn_count
);

    localparam int unsigned WAIT_W = $clog2(BUSY_CYCLES);

    // Elaboration-time guards on the parameter ranges.
    if (BUSY_CYCLES < LRU_MIN_BUSY) begin : g_busy_chk
        $error("BUSY_CYCLES below the buffer's worst-case miss path");
    end
    if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_nreq_chk
        $error("N_REQ must be in 2..4");
    end

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    logic [N_REQ-1:0]  gnt_d;
    logic [N_REQ-1:0]  done_d;
    logic              lru_valid_d;
    logic [DATA_W-1:0] lru_data_d;
    logic              busy_d;
    logic [IDX_W-1:0]  last_src_d;
    logic [CNT_W-1:0]  txn_count_d;

    logic [N_REQ-1:0]  pick_sel;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .sel     (pick_sel),
        .sel_idx (pick_idx),
        .any     (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and internal bookkeeping.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        done_d      = done;
        lru_valid_d = lru_valid;
        lru_data_d  = lru_data;
        last_src_d  = last_src;
        txn_count_d = txn_count;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    lru_data_d  = req_data[32'(pick_idx)*DATA_W +: DATA_W];
                    gnt_d       = pick_sel;
                    lru_valid_d = 1'b1;
                    last_src_d  = pick_idx;
                end
            end
            ISSUE: begin
                lru_valid_d = 1'b0;
                cnt_d       = WAIT_W'(BUSY_CYCLES - 1);
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    // gnt is still one-hot on the served requester here.
                    gnt_d    = '0;
                    done_d   = gnt;
                    rr_ptr_d = wrap_inc(last_src, N_REQ);
                    if (txn_count != '1) begin
                        txn_count_d = txn_count + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_d = '0;
            end
            default: begin
                done_d = '0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            lru_valid <= 1'b0;
            lru_data  <= '0;
            busy      <= 1'b0;
            last_src  <= '0;
            txn_count <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            done      <= done_d;
            lru_valid <= lru_valid_d;
            lru_data  <= lru_data_d;
            busy      <= busy_d;
            last_src  <= last_src_d;
            txn_count <= txn_count_d;
        end
    end

endmodule

// File: tb/tb_lru_access_arbiter.sv
// Directed bench for lru_access_arbiter; a second instance with a 2-bit
// transaction counter shares the stimulus to exercise saturation.
module tb_lru_access_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 12;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;

    logic [N-1:0]  gnt, done;
    logic          lru_valid, busy;
    logic [DW-1:0] lru_data;
    logic [1:0]    last_src;
    logic [7:0]    txn_count;

    logic [N-1:0]  s_gnt, s_done;
    logic          s_lru_valid, s_busy;
    logic [DW-1:0] s_lru_data;
    logic [1:0]    s_last_src;
    logic [1:0]    s_txn_count;

    int tests;
    int fails;

    lru_access_arbiter #(
        .N_REQ(N), .DATA_W(DW), .BUSY_CYCLES(12), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .lru_valid(lru_valid), .lru_data(lru_data),
        .busy(busy), .last_src(last_src), .txn_count(txn_count)
    );

    lru_access_arbiter #(
        .N_REQ(N), .DATA_W(DW), .BUSY_CYCLES(12), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(s_gnt), .done(s_done), .lru_valid(s_lru_valid), .lru_data(s_lru_data),
        .busy(s_busy), .last_src(s_last_src), .txn_count(s_txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".gnt"},       32'(gnt), 32'h0);
        chk({tag, ".done"},      32'(done), 32'h0);
        chk({tag, ".lru_valid"}, 32'(lru_valid), 32'h0);
        chk({tag, ".lru_data"},  32'(lru_data), 32'h0);
        chk({tag, ".busy"},      32'(busy), 32'h0);
        chk({tag, ".last_src"},  32'(last_src), 32'h0);
        chk({tag, ".txn_count"}, 32'(txn_count), 32'h0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        req      = '0;
        req_data = '0;

        // Reset state
        step(2);
        chk_reset_outputs("reset");
        rst = 1'b1;
        step(1);
        chk("idle_stays.busy", 32'(busy), 32'h0);

        // Single request from requester 0
        req_data[0*DW +: DW] = 12'h0A5;
        req = 4'b0001;
        step(1);
        chk("single.valid_t1", 32'(lru_valid), 32'h1);
        chk("single.data_t1",  32'(lru_data), 32'h0A5);
        chk("single.gnt_t1",   32'(gnt), 32'h1);
        chk("single.busy_t1",  32'(busy), 32'h1);
        step(1);
        chk("single.valid_t2", 32'(lru_valid), 32'h0);
        chk("single.gnt_t2",   32'(gnt), 32'h1);
        step(11);
        chk("single.gnt_t13",  32'(gnt), 32'h1);
        chk("single.done_t13", 32'(done), 32'h0);
        step(1);
        chk("single.done_t14", 32'(done), 32'h1);
        chk("single.gnt_t14",  32'(gnt), 32'h0);
        chk("single.txn_t14",  32'(txn_count), 32'h1);
        req = '0;
        step(1);
        chk("single.done_t15", 32'(done), 32'h0);
        chk("single.busy_t15", 32'(busy), 32'h0);
        chk("single.data_hold", 32'(lru_data), 32'h0A5);

        // Round-robin rotation from a fresh reset
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 12'(i + 1);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step(1);
            chk("rr.gnt",      32'(gnt), 32'(1) << (n % 4));
            chk("rr.last_src", 32'(last_src), 32'(n % 4));
            chk("rr.data",     32'(lru_data), 32'(n % 4 + 1));
            chk("rr.valid",    32'(lru_valid), 32'h1);
            step(13);
            chk("rr.done",     32'(done), 32'(1) << (n % 4));
            if (n == 4) req = '0;
            step(1);
        end
        chk("rr.txn_count",  32'(txn_count), 32'd5);
        chk("sat.txn_count", 32'(s_txn_count), 32'd3);
        chk("rr.idle_after", 32'(busy), 32'h0);

        // Pointer wrap: serve 3, then req 1001 grants 0 before 3
        req = 4'b1000;
        step(1);
        chk("wrap.gnt3", 32'(gnt), 32'h8);
        step(13);
        req = 4'b1001;
        step(2);
        chk("wrap.gnt0",      32'(gnt), 32'h1);
        chk("wrap.last_src0", 32'(last_src), 32'h0);
        step(13);
        chk("wrap.done0", 32'(done), 32'h1);
        step(2);
        chk("wrap.gnt3b",     32'(gnt), 32'h8);
        chk("wrap.last_src3", 32'(last_src), 32'h3);
        step(13);
        req = '0;
        step(1);

        // Request dropped and data changed after the grant
        req_data[2*DW +: DW] = 12'h3C3;
        req = 4'b0100;
        step(1);
        chk("drop.gnt",  32'(gnt), 32'h4);
        chk("drop.data", 32'(lru_data), 32'h3C3);
        step(2);
        req_data[2*DW +: DW] = 12'hFFF;
        step(2);
        req = '0;
        step(8);
        chk("drop.data_t13", 32'(lru_data), 32'h3C3);
        chk("drop.gnt_t13",  32'(gnt), 32'h4);
        step(1);
        chk("drop.done_t14", 32'(done), 32'h4);
        step(1);
        chk("drop.data_t15", 32'(lru_data), 32'h3C3);
        chk("drop.busy_t15", 32'(busy), 32'h0);

        // Reset mid-transaction
        req_data[1*DW +: DW] = 12'h111;
        req = 4'b0010;
        step(1);
        chk("midrst.gnt", 32'(gnt), 32'h2);
        step(6);
        rst = 1'b0;
        req = '0;
        step(1);
        chk_reset_outputs("midrst");
        step(1);
        chk("midrst.done_hold", 32'(done), 32'h0);
        rst = 1'b1;
        req_data[2*DW +: DW] = 12'h222;
        req = 4'b0100;
        step(1);
        chk("midrst.regnt",   32'(gnt), 32'h4);
        chk("midrst.revalid", 32'(lru_valid), 32'h1);
        chk("midrst.redata",  32'(lru_data), 32'h222);
        step(13);
        chk("midrst.redone", 32'(done), 32'h4);
        chk("midrst.retxn",  32'(txn_count), 32'h1);
        req = '0;

        // Lone requester held: back-to-back grants
        req_data[3*DW +: DW] = 12'h777;
        step(1);
        req = 4'b1000;
        step(1);
        chk("lone.gnt_a", 32'(gnt), 32'h8);
        step(15);
        chk("lone.gnt_b",   32'(gnt), 32'h8);
        chk("lone.valid_b", 32'(lru_valid), 32'h1);
        step(13);
        chk("lone.txn", 32'(txn_count), 32'h3);
        req = '0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lru_access_arbiter.md
# lru_access_arbiter

Round-robin controller that shares one LRU buffer (12-bit entries, `valid_data`/`data` input pair, no ready/ack) between up to four requesters. It serialises requests and issues a single-cycle `valid_data` pulse per transaction. `lru_data` is held stable for a fixed service window that covers the buffer's worst-case lookup/update time. Each transaction is reported back to its requester with a `done` pulse. It sits between the input sources (switch debouncer, UART receiver, test pattern generator) and the LRU buffer.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..4.
- `DATA_W`, 12: entry width; matches the LRU buffer.
- `BUSY_CYCLES`, 12: length of the WAIT window. Must be ≥ 11, the buffer's worst-case miss path.
- `CNT_W`, 8: width of the transaction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset. Also routed to the LRU buffer.
- `req` in N_REQ: per-requester request level. Held high until the matching `done`.
- `req_data` in N_REQ*DATA_W: requester i's data is in bits [i*DATA_W +: DATA_W]. Sampled only at grant.
- `gnt` out N_REQ: one-hot grant, high during ISSUE and WAIT.
- `done` out N_REQ: one-hot, 1-cycle completion pulse.
- `lru_valid` out 1: drives buffer `valid_data`; exactly one cycle high per transaction.
- `lru_data` out DATA_W: drives buffer `data`; holds its value until the next grant.
- `busy` out 1: high in any state except IDLE.
- `last_src` out 2: index of the most recently granted requester.
- `txn_count` out CNT_W: count of completed transactions; saturates at all-ones.

## Operation
- All outputs are registered.
- Reset value of every output is 0. Internal registers at reset:
  - state = IDLE
  - rr_ptr = 0
  - wait counter = 0
- States:
  - **IDLE**:
    - If `req` != 0, select the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
    - At that edge: latch its `req_data` into `lru_data`, set `gnt[i]`, set `lru_valid`=1, set `last_src`=i, go to ISSUE.
    - If `req` == 0, stay in IDLE.
  - **ISSUE**: clear `lru_valid`, load the counter with BUSY_CYCLES-1, go to WAIT.
  - **WAIT**:
    - Counter != 0: decrement it.
    - Counter == 0: clear `gnt`, set `done[i]`=1, increment `txn_count` (saturating), set rr_ptr = (i+1) mod N_REQ, go to DONE.
  - **DONE**: clear `done`, go to IDLE. `req` is ignored in this state, so requesters can drop `req` after seeing `done`.
- Boundary conditions:
  - `req[i]` dropped during ISSUE/WAIT: the transaction still completes and `done[i]` still pulses.
  - `req` bits at or above N_REQ are ignored.
  - All requesters continuously requesting: grants rotate 0,1,2,3,0…
  - A lone requester holding `req` is re-granted back-to-back; each grant is a new transaction.
  - `req_data` changing after the grant does not affect `lru_data`.
  - `txn_count` at 2^CNT_W-1 stays there.
- Reset mid-transaction: all state and outputs return to reset values at the next edge. No `done` is issued. The buffer is reset by the same `rst`.

## Timing
- `req` first seen high in IDLE at cycle T:
  - `gnt`, `lru_data`, `lru_valid` valid at T+1 (ISSUE).
  - WAIT occupies T+2 … T+1+BUSY_CYCLES.
  - `done` high at T+2+BUSY_CYCLES (DONE).
  - IDLE at T+3+BUSY_CYCLES; earliest next `lru_valid` at T+4+BUSY_CYCLES.
- Per-transaction period is BUSY_CYCLES+3 cycles; 15 with the default.
- Grant latency from `req` to `gnt` is 1 cycle when IDLE. Otherwise it is bounded by (N_REQ-1)*(BUSY_CYCLES+3) plus the residual of the current transaction.
- `lru_data` is stable from T+1 through at least T+2+BUSY_CYCLES.

## Structure
- Shared package `lru_pkg`:
  - state encoding constants IDLE=0, ISSUE=1, WAIT=2, DONE=3
  - default DATA_W = 12
  - LRU_MIN_BUSY = 11, used for a BUSY_CYCLES parameter check
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot `sel`, index `sel_idx`, `any`.
- Top-level instance pairs `lru_access_arbiter` with the LRU buffer and shares `clk`/`rst`.

## Test plan
- **Single request:** reset, then `req`=0001 with data 0x0A5 at T → `lru_valid` high only at T+1, `lru_data`=0x0A5, `gnt`=0001 for T+1..T+13, `done`=0001 at T+14, `txn_count`=1.
- **Round-robin fairness:** `req`=1111 held, data 0x001/0x002/0x003/0x004 → grants in order 0,1,2,3,0, one every 15 cycles; buffer slots 0..3 read back 0x001..0x004 via `sw`.
- **Pointer wrap:** after serving requester 3, `req`=1001 → requester 0 is granted next, then requester 3.
- **Drop and data change:** `req[2]` dropped at T+5 and `req_data` changed at T+3 → `lru_data` unchanged, `done[2]` still at T+14.
- **Reset mid-transaction:** `rst`=0 at T+7 → next edge has all outputs 0 and state IDLE, no `done`; a request after release is granted 1 cycle after it is seen.
- **Saturation:** with CNT_W=2, run 5 transactions → `txn_count` stops at 3.
